// File: rtl/otter_intr_ctrl.sv
// Interrupt controller and machine-mode CSR block for the OTTER MCU.
//
// Synchronises the external interrupt line, detects its rising edge and holds it
// as a pending request. Sequences trap entry with CU_FSM and handles mret return.
// Holds mstatus.MIE/MPIE, mtvec and mepc, and supplies the CSR read value.
//
// Ports:
//   clk            system clock, all state updates on rising edge
//   rst            synchronous active-high reset
//   intr_in        raw asynchronous external interrupt request (rising-edge sensitive)
//   instr_boundary high for one cycle while CU_FSM is in FETCH
//   int_taken      high for one cycle while CU_FSM is in its INTR state
//   mret_exec      high for one cycle when an mret executes
//   csr_we         CSR write strobe
//   csr_addr       CSR address (ir[31:20])
//   csr_wd         CSR write data (rs1)
//   pc             current PC
//   trap_req       request to CU_FSM to enter the INTR state
//   csr_rd         combinational CSR read data for csr_addr
//   mtvec_out      trap vector to the PC mux
//   mepc_out       return address to the PC mux
//   mie_out        current mstatus.MIE
module otter_intr_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr_in,
  input  logic        instr_boundary,
  input  logic        int_taken,
  input  logic        mret_exec,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  input  logic [31:0] pc,
  output logic        trap_req,
  output logic [31:0] csr_rd,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  // Fewer than two stages is not metastability-safe; clamp.
  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMip     = 12'h344;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StTrapEntry,
    StIsr
  } state_e;

  state_e              state_q, state_d;
  logic [Stages-1:0]   sync_q, sync_d;
  logic                delay_q;
  logic                pend_q, pend_d;
  logic                armed_q, armed_d;
  logic                mie_q, mie_d;
  logic                mpie_q, mpie_d;
  logic [31:0]         mepc_q, mepc_d;
  logic [31:0]         mtvec_q, mtvec_d;

  logic rise;
  logic take;
  logic mret;
  logic wr_mstatus, wr_mtvec, wr_mepc;
  logic unused_bits;

  assign sync_d = {sync_q[Stages-2:0], intr_in};
  assign rise   = sync_q[Stages-1] & ~delay_q;

  // int_taken only counts if CU_FSM saw trap_req at an earlier instruction boundary.
  assign take = (state_q == StPend) & mie_q & armed_q & int_taken;
  assign mret = (state_q == StIsr) & mret_exec;

  assign wr_mstatus = csr_we & (csr_addr == AddrMstatus);
  assign wr_mtvec   = csr_we & (csr_addr == AddrMtvec);
  assign wr_mepc    = csr_we & (csr_addr == AddrMepc);

  // Low address bits are always forced to zero and never stored.
  assign unused_bits = ^{csr_wd[1:0], pc[1:0]};

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    mepc_d  = mepc_q;
    mtvec_d = mtvec_q;

    armed_d = (state_q == StPend) & mie_q & ~take & (armed_q | instr_boundary);

    // Software writes first; trap entry and mret below override them.
    if (wr_mstatus) begin
      mie_d  = csr_wd[3];
      mpie_d = csr_wd[7];
    end
    if (wr_mtvec) begin
      mtvec_d = {csr_wd[31:2], 2'b00};
    end
    if (wr_mepc) begin
      mepc_d = {csr_wd[31:2], 2'b00};
    end

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StPend;
        end
      end
      StPend: begin
        // Further rises merge into the request already pending.
        if (take) begin
          state_d = StTrapEntry;
        end
      end
      StTrapEntry: begin
        mepc_d  = {pc[31:2], 2'b00};
        mpie_d  = mie_q;
        mie_d   = 1'b0;
        // Keep an edge arriving during the single entry cycle for replay after mret.
        if (rise) begin
          pend_d = 1'b1;
        end
        state_d = StIsr;
      end
      StIsr: begin
        if (rise) begin
          pend_d = 1'b1;
        end
        if (mret) begin
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = (pend_q | rise) ? StPend : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sync_q  <= '0;
      delay_q <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      mepc_q  <= '0;
      mtvec_q <= {MTVEC_RST[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      delay_q <= sync_q[Stages-1];
      pend_q  <= pend_d;
      armed_q <= armed_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      mepc_q  <= mepc_d;
      mtvec_q <= mtvec_d;
    end
  end

  assign trap_req  = (state_q == StPend) & mie_q;
  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;
  assign mie_out   = mie_q;

  always_comb begin
    csr_rd = '0;
    case (csr_addr)
      AddrMstatus: begin
        csr_rd[3] = mie_q;
        csr_rd[7] = mpie_q;
      end
      AddrMtvec:   csr_rd = mtvec_q;
      AddrMepc:    csr_rd = mepc_q;
      AddrMip:     csr_rd[11] = (state_q == StPend) | pend_q;
      default:     csr_rd = '0;
    endcase
  end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
Interrupt controller and machine-mode CSR block for the OTTER MCU. It synchronises the external interrupt line and latches it as pending. It sequences trap entry with CU_FSM at instruction boundaries and handles mret return. It holds mstatus.MIE/MPIE, mtvec and mepc, and supplies the CSR read value to the register-file write mux (rf_wr_sel = 1).

Parameters:
SYNC_STAGES, 2, number of flops synchronising intr_in (minimum 2)
MTVEC_RST, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored, forced 0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
intr_in  input  1  raw asynchronous external interrupt request, rising-edge sensitive
instr_boundary  input  1  high for one cycle when CU_FSM is in FETCH (no instruction in flight)
int_taken  input  1  high for one cycle when CU_FSM is in its INTR state
mret_exec  input  1  high for one cycle when an mret executes
csr_we  input  1  CSR write strobe (CSRRW execute cycle)
csr_addr  input  12  CSR address (ir[31:20])
csr_wd  input  32  CSR write data (rs1)
pc  input  32  current PC
trap_req  output  1  request to CU_FSM to enter the INTR state
csr_rd  output  32  combinational CSR read data for csr_addr
mtvec_out  output  32  trap vector, drives the PC mux trap input
mepc_out  output  32  return address, drives the PC mux mret input
mie_out  output  1  current mstatus.MIE

Behaviour:
- Reset (rst high at rising edge): state=IDLE; sync chain=0; edge flop=0; sticky pend_q=0; MIE=0; MPIE=0; mepc=0; mtvec=MTVEC_RST. Outputs after reset: trap_req=0, mie_out=0, mepc_out=0, mtvec_out=MTVEC_RST. rst mid-trap or in ISR aborts to IDLE and drops any pending request.
- Synchroniser: intr_in passes through SYNC_STAGES flops, plus one delay flop. rise = sync_last & ~delay.
- With SYNC_STAGES=2, intr_in high before edge k gives rise=1 during the cycle after edge k+1. The state reaches PEND at edge k+2.
- FSM states:
  - IDLE: rise -> PEND.
  - PEND: trap_req = MIE. Further rises are ignored. int_taken -> TRAP_ENTRY. int_taken while MIE=0 is a CU_FSM error and is ignored.
  - TRAP_ENTRY (1 cycle): mepc <= {pc[31:2],2'b00}; MPIE <= MIE; MIE <= 0 -> ISR.
  - ISR: a rise sets pend_q. On mret_exec: MIE <= MPIE; MPIE <= 1; pend_q <= 0; next state = PEND if (pend_q | rise), else IDLE.
- trap_req is registered-state-derived (PEND & MIE). CU_FSM samples it only when instr_boundary=1, so the controller never needs instr_boundary to gate state. instr_boundary only qualifies int_taken: int_taken without the prior instr_boundary cycle is ignored.
- trap_req deasserts in the cycle after int_taken.
- CSR map:
  - 0x300 mstatus: bit3 MIE, bit7 MPIE, other bits read 0 and ignore writes.
  - 0x305 mtvec: bits[1:0] read 0.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x344 mip: bit11 = (state==PEND) | pend_q, read-only.
  - Any other address reads 0 and ignores writes.
- CSR writes take effect at the next edge. csr_rd is combinational from current register values (old value visible in the write cycle).
- Collisions:
  - TRAP_ENTRY vs csr_we to mstatus/mepc: TRAP_ENTRY wins for MIE/MPIE/mepc. A write to mtvec still occurs.
  - mret_exec vs csr_we to mstatus in the same cycle: mret result wins.
  - rise in the same cycle as mret_exec in ISR: counted, next state PEND.
- Writing MIE=1 while in PEND asserts trap_req the following cycle.

Test Plan:
- Reset, then read 0x300/0x305/0x341 -> 0/MTVEC_RST/0; trap_req=0; mie_out=0.
- Write mtvec=0x0000_0103, mstatus=0x8 -> read mtvec=0x100, mie_out=1. Pulse intr_in (1 cycle at edge k) -> trap_req=1 from edge k+2. Assert instr_boundary then int_taken with pc=0x40 -> mepc=0x40, mie_out=0, MPIE=1, trap_req=0.
- MIE=0, pulse intr_in -> mip bit11=1, trap_req stays 0 for 20 cycles. Write mstatus=0x8 -> trap_req=1 next cycle.
- In ISR, pulse intr_in, then mret_exec -> mie_out=1, mip bit11 stays 1, trap_req=1 the following cycle (nested-pending replay).
- Same cycle mret_exec and csr_we 0x300 data 0 -> mie_out=1 (mret wins). Same cycle TRAP_ENTRY and csr_we 0x341=0xFFFF_FFFC -> mepc=pc.
- rst asserted while in ISR with pend_q=1 -> state IDLE, mip=0, mepc=0, trap_req=0. intr_in held high continuously after reset -> exactly one trap (level does not retrigger).
